// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator
// Purpose  : N-stage CIC decimator, ratio R, truncating output scaling.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decimator #(
    parameter int N  = 3,
    parameter int R  = 8,
    parameter int IW = 12,
    parameter int OW = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data
);

    localparam int BW = IW + N * $clog2(R);
    localparam int PW = $clog2(R);
    localparam logic [PW-1:0] C_LAST = PW'(R - 1);

    logic [BW-1:0] r_integ    [N];
    logic [BW-1:0] r_comb_dly [N];
    logic [BW-1:0] w_comb_in  [N];
    logic [BW-1:0] w_comb_out [N];
    logic [BW-1:0] w_in_ext;
    logic [PW-1:0] r_phase;
    logic          r_strobe;
    logic          w_last;

    assign w_in_ext = {{(BW-IW){in_data[IW-1]}}, in_data};
    assign w_last   = (r_phase == C_LAST);

    // Each stage adds the pre-update value of its predecessor: one pipeline
    // register per stage, all wrapping modulo 2^BW.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_integ[i] <= '0;
            end
        end else if (in_valid) begin
            r_integ[0] <= r_integ[0] + w_in_ext;
            for (int k = 1; k < N; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= in_valid && w_last;
            if (in_valid) begin
                r_phase <= w_last ? '0 : r_phase + PW'(1);
            end
        end
    end

    assign w_comb_in[0] = r_integ[N-1];

    generate
        for (genvar k = 0; k < N; k++) begin : g_comb
            assign w_comb_out[k] = w_comb_in[k] - r_comb_dly[k];
            if (k < N - 1) begin : g_link
                assign w_comb_in[k+1] = w_comb_out[k];
            end
        end
    endgenerate

    // Comb delays and the output register only move on the decimation strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_comb_dly[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= r_strobe;
            if (r_strobe) begin
                for (int i = 0; i < N; i++) begin
                    r_comb_dly[i] <= w_comb_in[i];
                end
                out_data <= w_comb_out[N-1][BW-1 -: OW];
            end
        end
    end

endmodule
`default_nettype wire
